mcu_uart: RTL and testbench

Memory-mapped UART peripheral that sits directly downstream of the 8051 bus front end and occupies one chip-select slot (one `mcu_cs` bit, 16-byte window). It takes the decoded chip select, read/write strobes, low address nibble and write data, and returns read data and a level interrupt for the front end's read mux and INT0 OR-tree. The UART core has 8N1 framing, a programmable 16-bit bit-period divisor, and TX/RX FIFOs.

---
 rtl/mcu_uart_pkg.sv | 40 ++++
 rtl/mcu_uart_if.sv | 22 ++
 rtl/mcu_uart_fifo.sv | 65 ++++++
 rtl/mcu_uart.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_mcu_uart.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_uart_pkg.sv
// mcu_uart_pkg: shared constants for the memory-mapped UART.
//   - register offsets within the 16-byte chip-select window
//   - STAT / CTRL bit positions
//   - serial FSM state encoding (shared by TX and RX)
//   - minimum bit-period divisor and the clamp helper
package mcu_uart_pkg;

  localparam logic [3:0] REG_DATA    = 4'h0;
  localparam logic [3:0] REG_STAT    = 4'h1;
  localparam logic [3:0] REG_CTRL    = 4'h2;
  localparam logic [3:0] REG_BAUD_LO = 4'h3;
  localparam logic [3:0] REG_BAUD_HI = 4'h4;

  localparam int STAT_RX_AVAIL = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_OVERRUN  = 4;
  localparam int STAT_FRAME    = 5;

  localparam int CTRL_TX_EN = 0;
  localparam int CTRL_RX_EN = 1;
  localparam int CTRL_RX_IE = 2;
  localparam int CTRL_TX_IE = 3;

  localparam logic [15:0] DIV_MIN = 16'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Very short bit periods leave no room for the mid-bit sample point.
  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

endpackage

// File: rtl/mcu_uart_if.sv
// mcu_uart_if: 8051 front-end slot bus as seen by one peripheral.
//   master: drives cs / rd / wr strobes, address nibble and write data.
//   slave : returns combinational read data and the level interrupt.
interface mcu_uart_if;
  logic       mcu_cs_i;
  logic       mcu_rd_i;
  logic       mcu_wr_i;
  logic [3:0] mcu_addr_i4;
  logic [7:0] mcu_wrdat_i8;
  logic [7:0] mcu_rddat_o8;
  logic       mcu_int_o;

  modport master (
    output mcu_cs_i, mcu_rd_i, mcu_wr_i, mcu_addr_i4, mcu_wrdat_i8,
    input  mcu_rddat_o8, mcu_int_o
  );

  modport slave (
    input  mcu_cs_i, mcu_rd_i, mcu_wr_i, mcu_addr_i4, mcu_wrdat_i8,
    output mcu_rddat_o8, mcu_int_o
  );
endinterface

// File: rtl/mcu_uart_fifo.sv
// uart_fifo: synchronous FIFO with wrap-around pointers and an occupancy count.
//   clk_i/rst_i : clock, async active-high reset
//   push_i/data_i : write request and data
//   pop_i        : read request (ignored when empty)
//   full_o/empty_o/head_o : status and current head entry
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; the slot being vacated is the one written.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/mcu_uart.sv
// mcu_uart: memory-mapped 8N1 UART on one 8051 chip-select slot.
//   clk_i       : peripheral clock
//   mcu_rst_i   : async active-high reset
//   bus         : slot bus (cs/rd/wr/addr/wrdat in, rddat/int out)
//   uart_txd_o  : serial out, idles high
//   uart_rxd_i  : serial in, asynchronous
// Bus strobes are asynchronous: they are synchronised and acted on at their
// falling edge, so the read data driven during the strobe is what the CPU
// latches before any pop or sticky clear takes effect.
module mcu_uart
  import mcu_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] BAUD_DIV_RST = 16'd191
) (
  input  logic        clk_i,
  input  logic        mcu_rst_i,
  mcu_uart_if.slave   bus,
  output logic        uart_txd_o,
  input  logic        uart_rxd_i
);

  // ---------------- bus strobe capture ----------------
  logic [2:0] wr_sync_q, wr_sync_d, rd_sync_q, rd_sync_d;
  logic       wr_fire, rd_fire;

  always_comb begin
    wr_sync_d = {wr_sync_q[1:0], bus.mcu_cs_i & bus.mcu_wr_i};
    rd_sync_d = {rd_sync_q[1:0], bus.mcu_cs_i & bus.mcu_rd_i};
  end

  // [1] is the synchronised level, [2] its previous value.
  assign wr_fire = wr_sync_q[2] & ~wr_sync_q[1];
  assign rd_fire = rd_sync_q[2] & ~rd_sync_q[1];

  // ---------------- registers ----------------
  logic [3:0]  ctrl_q, ctrl_d;
  logic [7:0]  baud_lo_q, baud_lo_d;
  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d, fe_q, fe_d;
  logic [15:0] eff_div, half_m1;

  logic tx_push, rx_pop, stat_clr;

  assign tx_push  = wr_fire & (bus.mcu_addr_i4 == REG_DATA);
  assign rx_pop   = rd_fire & (bus.mcu_addr_i4 == REG_DATA);
  assign stat_clr = rd_fire & (bus.mcu_addr_i4 == REG_STAT);

  assign eff_div = clamp_div(div_q);
  // (div+1)/2 - 1: count for the start-bit recheck at mid-bit.
  assign half_m1 = {1'b0, eff_div[15:1]} + {15'd0, eff_div[0]} - 16'd1;

  // ---------------- FIFOs ----------------
  logic       tx_full, tx_empty, tx_pop;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty, rx_push;
  logic [7:0] rx_head;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (mcu_rst_i),
    .push_i  (tx_push),
    .data_i  (bus.mcu_wrdat_i8),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

  logic [7:0] rx_shift_q, rx_shift_d;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (mcu_rst_i),
    .push_i  (rx_push),
    .data_i  (rx_shift_q),
    .pop_i   (rx_pop),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

  // ---------------- TX FSM ----------------
  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  // Bit counters are reloaded from eff_div only at bit boundaries, so a
  // divisor commit never stretches or shortens the bit in flight.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (ctrl_q[CTRL_TX_EN] && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = eff_div;
          txd_d      = 1'b0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = eff_div;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = eff_div;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        if (tx_cnt_q == 16'd0) tx_state_d = ST_IDLE;
        else                   tx_cnt_d   = tx_cnt_q - 16'd1;
      end
      default: begin
        txd_d      = 1'b1;
        tx_state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------- RX FSM ----------------
  logic [2:0]  rx_sync_q, rx_sync_d;
  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_line, rx_fall, rx_fe_set, rx_ovr_set;

  assign rx_sync_d = {rx_sync_q[1:0], uart_rxd_i};
  assign rx_line   = rx_sync_q[1];
  assign rx_fall   = rx_sync_q[2] & ~rx_sync_q[1];

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_fe_set  = 1'b0;
    rx_ovr_set = 1'b0;
    if (!ctrl_q[CTRL_RX_EN]) begin
      rx_state_d = ST_IDLE;
    end else begin
      case (rx_state_q)
        ST_IDLE: begin
          if (rx_fall) begin
            rx_cnt_d   = half_m1;
            rx_state_d = ST_START;
          end
        end
        ST_START: begin
          if (rx_cnt_q == 16'd0) begin
            if (rx_line) begin
              rx_state_d = ST_IDLE;   // line back high: glitch, not a start bit
            end else begin
              rx_cnt_d   = eff_div;
              rx_bit_d   = 3'd0;
              rx_state_d = ST_DATA;
            end
          end else begin
            rx_cnt_d = rx_cnt_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_cnt_q == 16'd0) begin
            rx_shift_d = {rx_line, rx_shift_q[7:1]};
            rx_cnt_d   = eff_div;
            if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_cnt_d = rx_cnt_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (rx_cnt_q == 16'd0) begin
            rx_state_d = ST_IDLE;
            if (!rx_line)                rx_fe_set  = 1'b1;
            else if (rx_full && !rx_pop) rx_ovr_set = 1'b1;
            else                         rx_push    = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q - 16'd1;
          end
        end
        default: rx_state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- register writes and sticky status ----------------
  always_comb begin
    ctrl_d    = ctrl_q;
    baud_lo_d = baud_lo_q;
    div_d     = div_q;
    if (wr_fire) begin
      case (bus.mcu_addr_i4)
        REG_CTRL:    ctrl_d    = bus.mcu_wrdat_i8[3:0];
        REG_BAUD_LO: baud_lo_d = bus.mcu_wrdat_i8;
        REG_BAUD_HI: div_d     = {bus.mcu_wrdat_i8, baud_lo_q};
        default: ;
      endcase
    end
    // Set terms are OR-ed after the clear so a same-cycle set survives.
    ovr_d = (ovr_q & ~stat_clr) | (tx_push & tx_full & ~tx_pop) | rx_ovr_set;
    fe_d  = (fe_q  & ~stat_clr) | rx_fe_set;
  end

  // ---------------- read mux and interrupt ----------------
  logic [7:0] rddat;

  always_comb begin
    rddat = 8'h00;
    case (bus.mcu_addr_i4)
      REG_DATA: if (!rx_empty) rddat = rx_head;
      REG_STAT: begin
        rddat[STAT_RX_AVAIL] = ~rx_empty;
        rddat[STAT_RX_FULL]  = rx_full;
        rddat[STAT_TX_EMPTY] = tx_empty;
        rddat[STAT_TX_FULL]  = tx_full;
        rddat[STAT_OVERRUN]  = ovr_q;
        rddat[STAT_FRAME]    = fe_q;
      end
      REG_CTRL: rddat = {4'h0, ctrl_q};
      default: ;
    endcase
  end

  assign bus.mcu_rddat_o8 = rddat;
  assign bus.mcu_int_o    = (ctrl_q[CTRL_RX_IE] & ~rx_empty) |
                            (ctrl_q[CTRL_TX_IE] & tx_empty);
  assign uart_txd_o       = txd_q;

  // ---------------- state registers ----------------
  always_ff @(posedge clk_i or posedge mcu_rst_i) begin
    if (mcu_rst_i) begin
      wr_sync_q  <= '0;
      rd_sync_q  <= '0;
      rx_sync_q  <= 3'b111;
      ctrl_q     <= '0;
      baud_lo_q  <= '0;
      div_q      <= BAUD_DIV_RST;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      wr_sync_q  <= wr_sync_d;
      rd_sync_q  <= rd_sync_d;
      rx_sync_q  <= rx_sync_d;
      ctrl_q     <= ctrl_d;
      baud_lo_q  <= baud_lo_d;
      div_q      <= div_d;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_mcu_uart.sv
// tb_mcu_uart: directed scoreboard bench for mcu_uart.
// Stimulus pushes expected values into queues; a bus/level monitor and a
// serial TX frame monitor pop and compare independently.
module tb_mcu_uart;
  import mcu_uart_pkg::*;

  logic clk, rst, rxd, txd;
  mcu_uart_if bus();

  mcu_uart #(.FIFO_DEPTH(4), .BAUD_DIV_RST(16'd191)) dut (
    .clk_i      (clk),
    .mcu_rst_i  (rst),
    .bus        (bus),
    .uart_txd_o (txd),
    .uart_rxd_i (rxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- bus / level scoreboard ----------------
  typedef enum {K_RD, K_TXD, K_INT} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  event       chk_ev;
  exp_t       sb_e;
  logic [7:0] sb_act;

  task automatic sb_push(input kind_e k, input logic [7:0] v, input string n);
    exp_t e;
    e.kind = k; e.val = v; e.name = n;
    sb_q.push_back(e);
    -> chk_ev;
  endtask

  always begin
    @(chk_ev);
    while (sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      case (sb_e.kind)
        K_RD:    sb_act = bus.mcu_rddat_o8;
        K_TXD:   sb_act = {7'd0, txd};
        default: sb_act = {7'd0, bus.mcu_int_o};
      endcase
      total++;
      if (sb_act !== sb_e.val) begin
        bad++;
        $display("FAIL %s: got %02h want %02h", sb_e.name, sb_act, sb_e.val);
      end
    end
  end

  // ---------------- serial TX frame monitor ----------------
  logic [7:0] tx_exp_q[$];
  int         tx_period = 4;
  bit         mon_en = 1'b1;
  bit         mon_busy = 1'b0;
  logic       mon_prev = 1'b1;
  int         mon_t, mon_k, mon_off;
  logic [9:0] mon_first, mon_last, mon_exp;

  // Each bit is sampled at its first and last clock; both must match, which
  // pins down both the level and the bit length.
  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
      mon_prev = 1'b1;
    end else begin
      if (!mon_busy && mon_en && mon_prev && !txd) begin
        mon_busy = 1'b1;
        mon_t    = 0;
      end
      if (mon_busy) begin
        mon_k   = mon_t / tx_period;
        mon_off = mon_t % tx_period;
        if (mon_off == 0)             mon_first[mon_k] = txd;
        if (mon_off == tx_period - 1) mon_last[mon_k]  = txd;
        mon_t++;
        if (mon_t == 10 * tx_period) begin
          mon_busy = 1'b0;
          if (tx_exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected_frame: got %03h want none", mon_first);
          end else begin
            mon_exp = {1'b1, tx_exp_q.pop_front(), 1'b0};
            total += 2;
            if (mon_first !== mon_exp) begin
              bad++;
              $display("FAIL tx_frame_bitstart: got %03h want %03h", mon_first, mon_exp);
            end
            if (mon_last !== mon_exp) begin
              bad++;
              $display("FAIL tx_frame_bitend: got %03h want %03h", mon_last, mon_exp);
            end
          end
        end
      end
      mon_prev = txd;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d, input int post = 5);
    @(negedge clk);
    bus.mcu_addr_i4 = a; bus.mcu_wrdat_i8 = d;
    bus.mcu_cs_i = 1'b1; bus.mcu_wr_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.mcu_wr_i = 1'b0; bus.mcu_cs_i = 1'b0;
    repeat (post) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [7:0] e, input string n);
    @(negedge clk);
    bus.mcu_addr_i4 = a;
    bus.mcu_cs_i = 1'b1; bus.mcu_rd_i = 1'b1;
    repeat (2) @(negedge clk);
    sb_push(K_RD, e, n);
    @(negedge clk);
    bus.mcu_rd_i = 1'b0; bus.mcu_cs_i = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input int per);
    rxd = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (per) @(negedge clk);
    end
    rxd = stop;
    repeat (per) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_tx_idle(input string n);
    int i;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tx_exp_q.size() == 0 && !mon_busy) break;
    end
    if (i == 600) begin
      total++; bad++;
      $display("FAIL %s: got timeout want frame done", n);
    end
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    int i;
    rst = 1'b1; rxd = 1'b1;
    bus.mcu_cs_i = 1'b0; bus.mcu_rd_i = 1'b0; bus.mcu_wr_i = 1'b0;
    bus.mcu_addr_i4 = 4'h0; bus.mcu_wrdat_i8 = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    sb_push(K_TXD, 8'h01, "rst_txd");
    sb_push(K_INT, 8'h00, "rst_int");
    bus_rd(REG_STAT, 8'h04, "rst_stat");
    bus_rd(REG_CTRL, 8'h00, "rst_ctrl");
    bus_rd(4'h7,     8'h00, "unmapped_rd");
    bus_rd(REG_DATA, 8'h00, "rx_empty_data");

    // TX 0xA5 at div=3
    bus_wr(REG_BAUD_LO, 8'h03);
    bus_wr(REG_BAUD_HI, 8'h00);
    bus_wr(REG_CTRL, 8'h01);
    tx_period = 4;
    tx_exp_q.push_back(8'hA5);
    bus_wr(REG_DATA, 8'hA5);
    wait_tx_idle("tx_a5_done");

    // divisor 1 clamps to 3: same 4-clk bits
    bus_wr(REG_BAUD_LO, 8'h01);
    bus_wr(REG_BAUD_HI, 8'h00);
    tx_exp_q.push_back(8'h5A);
    bus_wr(REG_DATA, 8'h5A);
    wait_tx_idle("tx_clamp_done");
    sb_push(K_TXD, 8'h01, "tx_idle_high");

    // tx_ie with empty TX FIFO raises the interrupt
    bus_wr(REG_CTRL, 8'h08);
    sb_push(K_INT, 8'h01, "tx_ie_int");
    bus_rd(REG_CTRL, 8'h08, "ctrl_rb");

    // RX 0x3C at div=7
    bus_wr(REG_BAUD_LO, 8'h07);
    bus_wr(REG_BAUD_HI, 8'h00);
    bus_wr(REG_CTRL, 8'h06);
    sb_push(K_INT, 8'h00, "rx_int_before");
    rx_frame(8'h3C, 1'b1, 8);
    repeat (8) @(negedge clk);
    sb_push(K_INT, 8'h01, "rx_int_set");
    bus_rd(REG_STAT, 8'h05, "rx_stat_avail");
    bus_rd(REG_DATA, 8'h3C, "rx_data");
    bus_rd(REG_STAT, 8'h04, "rx_stat_after_pop");
    sb_push(K_INT, 8'h00, "rx_int_clear");

    // frame error: stop bit low
    rx_frame(8'h81, 1'b0, 8);
    repeat (8) @(negedge clk);
    bus_rd(REG_STAT, 8'h24, "fe_stat");
    bus_rd(REG_DATA, 8'h00, "fe_no_data");
    bus_rd(REG_STAT, 8'h04, "fe_cleared");

    // 1-clk glitch is rejected
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (120) @(negedge clk);
    bus_rd(REG_STAT, 8'h04, "glitch_stat");
    sb_push(K_INT, 8'h00, "glitch_int");

    // TX overflow with tx_en off
    bus_wr(REG_CTRL, 8'h00);
    bus_wr(REG_DATA, 8'h11);
    bus_wr(REG_DATA, 8'h22);
    bus_wr(REG_DATA, 8'h33);
    bus_wr(REG_DATA, 8'h44);
    bus_wr(REG_DATA, 8'h55);
    bus_rd(REG_STAT, 8'h18, "ovr_stat");
    bus_rd(REG_STAT, 8'h08, "ovr_cleared");

    // reset in the middle of data bit 3 of 0x11 (line low there)
    mon_en = 1'b0;
    tx_period = 8;
    bus_wr(REG_CTRL, 8'h01, 0);
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd == 1'b0) break;
    end
    if (i == 60) begin
      total++; bad++;
      $display("FAIL rst_tx_start: got timeout want start bit");
    end
    repeat (36) @(negedge clk);
    sb_push(K_TXD, 8'h00, "txd_before_rst");
    rst = 1'b1;
    #1;
    sb_push(K_TXD, 8'h01, "txd_async_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus_rd(REG_STAT, 8'h04, "post_rst_stat");
    bus_rd(REG_CTRL, 8'h00, "post_rst_ctrl");
    sb_push(K_INT, 8'h00, "post_rst_int");
    sb_push(K_TXD, 8'h01, "post_rst_txd");

    if (tx_exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL tx_queue_drain: got %0d want 0", tx_exp_q.size());
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
